// File: rtl/issue_pkg.sv
// Shared definitions for the issue queue: sizing constants, issue-port encoding and the entry record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package issue_pkg;

    localparam int IQ_ISSUE_NUM = 4;
    localparam int IQ_PRF_WIDTH = 6;
    localparam int IQ_CIQ_DEPTH = 16;
    localparam int IQ_PAYLOAD_W = 32;
    localparam int IQ_PORT_W    = $clog2(IQ_ISSUE_NUM);

    // Issue port encoding. The MDU port is multi-cycle, so its grant does not
    // mean the destination tag is about to be written back.
    typedef enum logic [IQ_PORT_W-1:0] {
        PORT_ALU0 = 2'd0,
        PORT_ALU1 = 2'd1,
        PORT_MDU  = 2'd2,
        PORT_LSU  = 2'd3
    } iq_port_e;

    localparam int IQ_MDU_PORT = int'(PORT_MDU);

    typedef struct packed {
        logic                    valid;
        logic [IQ_PRF_WIDTH-1:0] prs1;
        logic [IQ_PRF_WIDTH-1:0] prs2;
        logic                    r1;
        logic                    r2;
        logic [IQ_PRF_WIDTH-1:0] prd;
        logic                    prd_v;
        logic [IQ_PORT_W-1:0]    port;
        logic [IQ_PAYLOAD_W-1:0] payload;
    } iq_entry_t;

endpackage

// File: rtl/issue_queue_prio_enc.sv
// Priority encoder: index of the lowest set request bit plus a found flag.
// Latency: combinational.
// Backpressure: none.
// Ports: req_i (W request bits), idx_o (lowest set index, 0 when none), found_o (any bit set).
module prio_enc #(
    parameter int W  = 16,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    // Scanning from the top down lets the lowest set bit be the last writer.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Centralised issue queue: holds dispatched micro-ops until both sources are ready, then issues per port.
// Latency: dispatch-to-issue-visible >= 2 cycles; wake-up to issue-visible exactly 1 cycle after the ready edge.
// Backpressure: disp_ready drops only when all CIQ_DEPTH entries are occupied; iss_stall[p] holds port p.
// Ports: clk/rst (sync, active-low), flush; disp_* dispatch write; ciq_prs*/prs*_rdy wake-up interface;
//        mc_tag* multi-cycle completion; iss_stall per-port busy; arbit_*/iss_payload registered issue; count.
module issue_queue
    import issue_pkg::*;
#(
    // Must match the package sizing, the entry record is built from it.
    parameter int ISSUE_NUM = IQ_ISSUE_NUM,
    parameter int PRF_WIDTH = IQ_PRF_WIDTH,
    parameter int CIQ_DEPTH = IQ_CIQ_DEPTH,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [PRF_WIDTH-1:0]         disp_prs1,
    input  logic [PRF_WIDTH-1:0]         disp_prs2,
    input  logic                         disp_prs1_rdy,
    input  logic                         disp_prs2_rdy,
    input  logic [PRF_WIDTH-1:0]         disp_prd,
    input  logic                         disp_prd_v,
    input  logic [$clog2(ISSUE_NUM)-1:0] disp_port,
    input  logic [PAYLOAD_W-1:0]         disp_payload,
    output logic [PRF_WIDTH-1:0]         ciq_prs1 [CIQ_DEPTH],
    output logic [PRF_WIDTH-1:0]         ciq_prs2 [CIQ_DEPTH],
    input  logic                         prs1_rdy [CIQ_DEPTH],
    input  logic                         prs2_rdy [CIQ_DEPTH],
    input  logic [PRF_WIDTH-1:0]         mc_tag,
    input  logic                         mc_tag_v,
    input  logic [ISSUE_NUM-1:0]         iss_stall,
    output logic [ISSUE_NUM-1:0]         arbit_grant,
    output logic [PRF_WIDTH-1:0]         arbit_prd [ISSUE_NUM],
    output logic [ISSUE_NUM-1:0]         arbit_prd_v,
    output logic [PAYLOAD_W-1:0]         iss_payload [ISSUE_NUM],
    output logic [$clog2(CIQ_DEPTH):0]   count
);

    localparam int PW = $clog2(ISSUE_NUM);
    localparam int IW = $clog2(CIQ_DEPTH);
    localparam int CW = IW + 1;

    iq_entry_t            ent_q   [CIQ_DEPTH];
    iq_entry_t            ent_d   [CIQ_DEPTH];
    logic [CW-1:0]        count_q, count_d;
    logic [ISSUE_NUM-1:0] grant_q, grant_d;
    logic [ISSUE_NUM-1:0] prd_v_q, prd_v_d;
    logic [PRF_WIDTH-1:0] prd_q   [ISSUE_NUM];
    logic [PRF_WIDTH-1:0] prd_d   [ISSUE_NUM];
    logic [PAYLOAD_W-1:0] pay_q   [ISSUE_NUM];
    logic [PAYLOAD_W-1:0] pay_d   [ISSUE_NUM];

    logic [CIQ_DEPTH-1:0] free_vec;
    logic [CIQ_DEPTH-1:0] elig_vec;
    logic [CIQ_DEPTH-1:0] port_req [ISSUE_NUM];
    logic [IW-1:0]        alloc_idx;
    logic                 alloc_found;
    logic [IW-1:0]        sel_idx  [ISSUE_NUM];
    logic [ISSUE_NUM-1:0] sel_found;
    logic                 accept;
    logic                 byp1, byp2;
    logic [CW-1:0]        n_sel;

    assign disp_ready  = (count_q < CW'(CIQ_DEPTH));
    assign accept      = disp_valid & disp_ready & alloc_found & ~flush;
    assign count       = count_q;
    assign arbit_grant = grant_q;
    assign arbit_prd_v = prd_v_q;

    // Eligibility uses registered ready bits only, so a wake-up is never
    // forwarded into the same cycle's selection.
    always_comb begin
        for (int i = 0; i < CIQ_DEPTH; i++) begin
            free_vec[i] = ~ent_q[i].valid;
            elig_vec[i] = ent_q[i].valid & ent_q[i].r1 & ent_q[i].r2;
            ciq_prs1[i] = ent_q[i].valid ? ent_q[i].prs1 : '0;
            ciq_prs2[i] = ent_q[i].valid ? ent_q[i].prs2 : '0;
        end
        for (int p = 0; p < ISSUE_NUM; p++) begin
            arbit_prd[p]   = prd_q[p];
            iss_payload[p] = pay_q[p];
            for (int i = 0; i < CIQ_DEPTH; i++) begin
                port_req[p][i] = elig_vec[i] & ~iss_stall[p] & (ent_q[i].port == PW'(p));
            end
        end
    end

    prio_enc #(.W(CIQ_DEPTH)) u_alloc (
        .req_i   (free_vec),
        .idx_o   (alloc_idx),
        .found_o (alloc_found)
    );

    for (genvar gp = 0; gp < ISSUE_NUM; gp++) begin : g_sel
        prio_enc #(.W(CIQ_DEPTH)) u_sel (
            .req_i   (port_req[gp]),
            .idx_o   (sel_idx[gp]),
            .found_o (sel_found[gp])
        );
    end

    // Sources already produced by an instruction issuing this cycle on a
    // single-cycle port, or completing on the multi-cycle bus, are captured as
    // ready at write time; otherwise the wake-up for them would be missed.
    always_comb begin
        byp1 = disp_prs1_rdy | (disp_prs1 == '0) | (mc_tag_v & (mc_tag == disp_prs1));
        byp2 = disp_prs2_rdy | (disp_prs2 == '0) | (mc_tag_v & (mc_tag == disp_prs2));
        for (int p = 0; p < ISSUE_NUM; p++) begin
            if (p != IQ_MDU_PORT && grant_q[p] && prd_v_q[p]) begin
                if (prd_q[p] == disp_prs1) byp1 = 1'b1;
                if (prd_q[p] == disp_prs2) byp2 = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CIQ_DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid) begin
                ent_d[i].r1 = ent_q[i].r1 | prs1_rdy[i];
                ent_d[i].r2 = ent_q[i].r2 | prs2_rdy[i];
            end
        end
        n_sel = '0;
        for (int p = 0; p < ISSUE_NUM; p++) begin
            grant_d[p] = sel_found[p];
            prd_d[p]   = sel_found[p] ? ent_q[sel_idx[p]].prd     : '0;
            prd_v_d[p] = sel_found[p] ? ent_q[sel_idx[p]].prd_v   : 1'b0;
            pay_d[p]   = sel_found[p] ? ent_q[sel_idx[p]].payload : '0;
            if (sel_found[p]) begin
                ent_d[sel_idx[p]].valid = 1'b0;
            end
            n_sel = n_sel + CW'(sel_found[p]);
        end
        // The allocated slot was invalid, so it can never collide with a selection.
        if (accept) begin
            ent_d[alloc_idx] = '{valid: 1'b1, prs1: disp_prs1, prs2: disp_prs2,
                                 r1: byp1, r2: byp2, prd: disp_prd, prd_v: disp_prd_v,
                                 port: disp_port, payload: disp_payload};
        end
        count_d = count_q + CW'(accept) - n_sel;
    end

    // Reset and flush have the same effect: empty queue, quiet issue outputs.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int i = 0; i < CIQ_DEPTH; i++) ent_q[i] <= '0;
            count_q <= '0;
            grant_q <= '0;
            prd_v_q <= '0;
            for (int p = 0; p < ISSUE_NUM; p++) begin
                prd_q[p] <= '0;
                pay_q[p] <= '0;
            end
        end else begin
            for (int i = 0; i < CIQ_DEPTH; i++) ent_q[i] <= ent_d[i];
            count_q <= count_d;
            grant_q <= grant_d;
            prd_v_q <= prd_v_d;
            for (int p = 0; p < ISSUE_NUM; p++) begin
                prd_q[p] <= prd_d[p];
                pay_q[p] <= pay_d[p];
            end
        end
    end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter ISSUE_NUM, 4, number of issue ports; port 2 is the multi-cycle mul/div port.
REQ-002 SHALL have parameter PRF_WIDTH, 6, physical register tag width.
REQ-003 SHALL have parameter CIQ_DEPTH, 16, number of queue entries.
REQ-004 SHALL have parameter PAYLOAD_W, 32, opaque micro-op payload width.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-low.
- flush  in  1  discard all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept.
- disp_prs1, disp_prs2  in  PRF_WIDTH  source tags.
- disp_prs1_rdy, disp_prs2_rdy  in  1  source ready at rename.
- disp_prd  in  PRF_WIDTH  destination tag.
- disp_prd_v  in  1  destination valid.
- disp_port  in  $clog2(ISSUE_NUM)  target issue port.
- disp_payload  in  PAYLOAD_W  micro-op.
- ciq_prs1[CIQ_DEPTH], ciq_prs2[CIQ_DEPTH]  out  PRF_WIDTH  entry source tags to wake_up.
- prs1_rdy[CIQ_DEPTH], prs2_rdy[CIQ_DEPTH]  in  1  tag-match results from wake_up.
- mc_tag  in  PRF_WIDTH; mc_tag_v  in  1  multi-cycle completion broadcast.
- iss_stall  in  ISSUE_NUM  per-port execution unit busy.
- arbit_grant  out  ISSUE_NUM  per-port issue valid.
- arbit_prd[ISSUE_NUM]  out  PRF_WIDTH; arbit_prd_v  out  ISSUE_NUM  issued destinations.
- iss_payload[ISSUE_NUM]  out  PAYLOAD_W  issued micro-ops.
- count  out  $clog2(CIQ_DEPTH)+1  occupied entries.

Function
REQ-006 Each entry SHALL hold valid, prs1, prs2, r1, r2, prd, prd_v, port, payload.
REQ-007 disp_ready SHALL equal (count < CIQ_DEPTH) from current state; a same-cycle issue SHALL NOT make a full queue accept.
REQ-008 On disp_valid & disp_ready & !flush the lowest-index invalid entry SHALL be written at the clock edge.
REQ-009 Written r1 SHALL be disp_prs1_rdy | (disp_prs1==0) | match of disp_prs1 against any port p≠2 with arbit_grant[p]&arbit_prd_v[p]&(arbit_prd[p]==disp_prs1) | (mc_tag_v & mc_tag==disp_prs1); r2 likewise.
REQ-010 Each cycle, for every valid entry, r1 SHALL become r1|prs1_rdy[i] and r2 SHALL become r2|prs2_rdy[i] at the edge.
REQ-011 ciq_prs1/ciq_prs2 SHALL drive the entry tags when valid, 0 when invalid.
REQ-012 Entry eligible = valid & r1 & r2 from registered state only; wake-up to issue latency SHALL be exactly one cycle.
REQ-013 Per port p with !iss_stall[p], the lowest-index eligible entry with port==p SHALL be selected and invalidated at the edge.
REQ-014 arbit_grant, arbit_prd, arbit_prd_v, iss_payload SHALL be registered; a selection at edge N is visible during cycle N+1.
REQ-015 arbit_grant[p] SHALL be 0 in any cycle after which no selection occurred for p; arbit_prd[p] SHALL then be 0.
REQ-016 count SHALL update as count + accepted − selected each cycle.
REQ-017 flush SHALL invalidate all entries, zero count and all arbit_* outputs at the edge; flush SHALL override dispatch and selection in that cycle.
REQ-018 An entry SHALL never be issued twice nor on a port other than its own.

Reset
REQ-019 On rst==0 at a clock edge all entries SHALL become invalid and count, arbit_grant, arbit_prd, arbit_prd_v, iss_payload SHALL become 0; disp_ready SHALL be 1 afterwards.
REQ-020 Reset asserted mid-operation SHALL discard in-flight dispatch and selection of that cycle.

Structure
REQ-021 Parameters, entry struct and port encoding (ALU0=0, ALU1=1, MDU=2, LSU=3) SHALL live in shared package issue_pkg.
REQ-022 One sub-module prio_enc (lowest-set-bit index plus found flag, CIQ_DEPTH wide) SHALL be instantiated for allocation and once per issue port.

Verification
REQ-023 Dispatch prs1=5,r1=0,prs2=0,port=0; drive prs1_rdy[0]=1 in cycle 3 -> arbit_grant[0]=1 in cycle 5, count back to 0.
REQ-024 Fill 16 entries, hold disp_valid, select one -> disp_ready 0 that cycle, 1 next cycle, 17th micro-op lands in the freed index.
REQ-025 Three ready port-1 entries at idx 2,7,9 -> issued in order 2,7,9 on consecutive cycles.
REQ-026 Dispatch prs1=12 while arbit_grant[0]=1, arbit_prd[0]=12, arbit_prd_v[0]=1 -> entry issues one cycle later without further wake-up.
REQ-027 Ready MDU entry with iss_stall[2]=1 for 4 cycles -> no grant[2] until stall drops, then grant next cycle.
REQ-028 flush with 6 valid entries and simultaneous dispatch -> count 0, no grants next cycle; rst=0 mid-run -> all outputs 0.
